// File: rtl/avalon_bus_arbiter_pkg.sv
// Shared types for the two-host Avalon-MM arbiter.
//   avalon_req_t  : host/device request (read, write, address, writedata, byte_enable)
//   avalon_resp_t : device/host response (readdata, readdatavalid, waitrequest)
//   arb_host_id_t : index of a host (0 = ibus, 1 = LSU dbus)
package avalon_bus_arbiter_pkg;

   typedef struct packed {
      logic        read;
      logic        write;
      logic [31:0] address;
      logic [31:0] writedata;
      logic [3:0]  byte_enable;
   } avalon_req_t;

   typedef struct packed {
      logic [31:0] readdata;
      logic        readdatavalid;
      logic        waitrequest;
   } avalon_resp_t;

   localparam int unsigned ARB_NUM_HOSTS = 2;

   typedef logic [0:0] arb_host_id_t;

   typedef enum logic {StIdle, StLocked} arb_state_e;

endpackage

// File: rtl/avalon_bus_arbiter_if.sv
// One Avalon-MM link: request travels master -> slave, response slave -> master.
//   master : drives req, receives resp (the device side of the arbiter)
//   slave  : receives req, drives resp (the host sides of the arbiter)
interface avalon_bus_arbiter_if;
   import avalon_bus_arbiter_pkg::*;

   avalon_req_t  req;
   avalon_resp_t resp;

   modport master (output req, input resp);
   modport slave  (input req, output resp);

endinterface

// File: rtl/avalon_bus_arbiter_id_fifo.sv
// In-order FIFO of host ids for reads accepted by the device but not yet returned.
//   clk, rst      : clock, synchronous active-low reset (clears the FIFO)
//   push, push_id : enqueue an id (ignored when full)
//   pop           : dequeue the head (ignored when empty)
//   full, empty   : occupancy flags
//   head          : id at the front of the queue
module avalon_bus_arbiter_id_fifo
   import avalon_bus_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  arb_host_id_t push_id,
   input  logic         pop,
   output logic         full,
   output logic         empty,
   output arb_host_id_t head
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   arb_host_id_t    mem_q [DEPTH];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] count_q;
   logic            do_push, do_pop;

   assign full    = (count_q == CntW'(DEPTH));
   assign empty   = (count_q == '0);
   assign head    = mem_q[rd_ptr_q];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_id;
            wr_ptr_q        <= wr_ptr_q + PtrW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
         // Simultaneous push and pop leaves the count unchanged.
         count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
      end
   end

endmodule

// File: rtl/avalon_bus_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM device port between host 0 (ibus)
// and host 1 (LSU dbus). Grants are held across device waitrequest, and read
// returns are routed back to the issuing host in order.
//   clk, rst   : clock, synchronous active-low reset
//   h0_avalon  : host 0 link (slave side)
//   h1_avalon  : host 1 link (slave side)
//   dev_avalon : shared device link (master side)
module avalon_bus_arbiter
   import avalon_bus_arbiter_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned DEFAULT_PRIO    = 0
) (
   input  logic          clk,
   input  logic          rst,
   avalon_bus_arbiter_if.slave  h0_avalon,
   avalon_bus_arbiter_if.slave  h1_avalon,
   avalon_bus_arbiter_if.master dev_avalon
);

   // last_grant starts opposite DEFAULT_PRIO so DEFAULT_PRIO wins the first tie.
   localparam arb_host_id_t RstLastGrant = arb_host_id_t'(DEFAULT_PRIO == 0);

   arb_state_e   state_q, state_d;
   arb_host_id_t last_grant_q, last_grant_d;
   arb_host_id_t locked_id_q, locked_id_d;

   avalon_req_t              host_req [ARB_NUM_HOSTS];
   logic [ARB_NUM_HOSTS-1:0] eligible;
   arb_host_id_t             gnt_id;
   logic                     gnt_valid, accept, push, pop;
   logic                     fifo_full, fifo_empty;
   arb_host_id_t             head_id;

   assign host_req[0] = h0_avalon.req;
   assign host_req[1] = h1_avalon.req;

   // A read cannot be forwarded while the id FIFO is full; writes always can.
   always_comb begin
      for (int i = 0; i < ARB_NUM_HOSTS; i++) begin
         eligible[i] = host_req[i].write | (host_req[i].read & ~fifo_full);
      end
   end

   always_comb begin
      gnt_id    = last_grant_q;
      gnt_valid = 1'b0;
      if (rst) begin
         if (state_q == StLocked) begin
            gnt_id    = locked_id_q;
            gnt_valid = eligible[locked_id_q];
         end else begin
            unique case (eligible)
               2'b01:   begin gnt_id = 1'b0;          gnt_valid = 1'b1; end
               2'b10:   begin gnt_id = 1'b1;          gnt_valid = 1'b1; end
               2'b11:   begin gnt_id = ~last_grant_q; gnt_valid = 1'b1; end
               default: begin gnt_id = last_grant_q;  gnt_valid = 1'b0; end
            endcase
         end
      end
   end

   assign accept = gnt_valid & ~dev_avalon.resp.waitrequest;
   assign push   = accept & host_req[gnt_id].read;
   // Returns with nothing outstanding (e.g. orphaned by a reset) are dropped.
   assign pop    = rst & dev_avalon.resp.readdatavalid & ~fifo_empty;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      locked_id_d  = locked_id_q;
      if (accept) begin
         state_d      = StIdle;
         last_grant_d = gnt_id;
      end else if (gnt_valid) begin
         state_d     = StLocked;
         locked_id_d = gnt_id;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= StIdle;
         last_grant_q <= RstLastGrant;
         locked_id_q  <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         locked_id_q  <= locked_id_d;
      end
   end

   always_comb begin
      dev_avalon.req = '0;
      if (gnt_valid) begin
         dev_avalon.req = host_req[gnt_id];
      end
      h0_avalon.resp = '{
         readdata:      dev_avalon.resp.readdata,
         readdatavalid: pop & (head_id == 1'b0),
         waitrequest:   ~(gnt_valid & (gnt_id == 1'b0)) | dev_avalon.resp.waitrequest
      };
      h1_avalon.resp = '{
         readdata:      dev_avalon.resp.readdata,
         readdatavalid: pop & (head_id == 1'b1),
         waitrequest:   ~(gnt_valid & (gnt_id == 1'b1)) | dev_avalon.resp.waitrequest
      };
   end

   avalon_bus_arbiter_id_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_id_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .push_id (gnt_id),
      .pop     (pop),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .head    (head_id)
   );

endmodule
